rst_req_ctrl: RTL and testbench
===============================

RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

Interface
REQ-001 The block SHALL have a parameter PulseCycles, default 16: minimum number of cycles prog_rst_no is held low per request (legal range 1..255).
REQ-002 The block SHALL have a parameter GuardCycles, default 4: number of post-release cycles in which new requests are dropped (legal range 1..255).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: power-on reset, synchronous, active-low.
REQ-005 The block SHALL have port sw_rst_req_i, input, 1 bit: software reset request, single-cycle pulse.
REQ-006 The block SHALL have port wdog_bite_i, input, 1 bit: watchdog timeout request, level or pulse.
REQ-007 The block SHALL have port prog_req_i, input, 1 bit: programming-mode request, level, held for the whole programming session.
REQ-008 The block SHALL have port cause_clr_i, input, 1 bit: clears rst_cause_o.
REQ-009 The block SHALL have port prog_rst_no, output, 1 bit: active-low reset request, driving the reset manager's prog_rst_ni.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port rst_cause_o, output, 3 bits: sticky causes {prog, wdog, sw} as bits [2:0].

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, ASSERT, HOLD and GUARD.
REQ-013 In IDLE, any of sw_rst_req_i, wdog_bite_i or prog_req_i high in a cycle SHALL be the trigger; on the next edge the FSM SHALL go to ASSERT and the counter SHALL load PulseCycles-1.
REQ-014 prog_rst_no SHALL be a registered output, low exactly while the FSM is in ASSERT or HOLD, so it falls one cycle after the trigger cycle.
REQ-015 ASSERT SHALL last exactly PulseCycles cycles, decrementing the counter each cycle.
REQ-016 At counter 0 in ASSERT, the FSM SHALL go to HOLD if prog_req_i is high in that cycle, otherwise to GUARD.
REQ-017 HOLD SHALL persist while prog_req_i is high; on the first cycle prog_req_i is low, the FSM SHALL go to GUARD.
REQ-018 GUARD SHALL keep prog_rst_no high for exactly GuardCycles cycles, then the FSM SHALL return to IDLE.
REQ-019 Requests arriving in ASSERT, HOLD or GUARD SHALL be dropped, not queued, and SHALL leave the cause bits unchanged.
REQ-020 A wdog_bite_i still high on return to IDLE SHALL start a new sequence.
REQ-021 Simultaneous requests in the trigger cycle SHALL start one sequence and set every corresponding cause bit.
REQ-022 Cause bits SHALL be set only in the trigger cycle.
REQ-023 cause_clr_i SHALL zero rst_cause_o on the next edge; when clear coincides with a trigger, the new bits SHALL win and all other bits SHALL clear.
REQ-024 The counter width SHALL be 8 bits, SHALL never wrap, and SHALL saturate at 0.

Reset
REQ-025 While rst_ni is low at a clock edge, the block SHALL apply: FSM=IDLE, counter=0, prog_rst_no=1, busy_o=0, rst_cause_o=3'b000.
REQ-026 rst_ni SHALL be connected to power-on reset only, never to sys_rst_ni, so the block survives the reset it requests.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence immediately and drop all pending state.

Configuration
REQ-028 With RST_REQ_CAUSE_EN defined, the cause register and cause_clr_i behaviour SHALL be as specified in REQ-021 to REQ-023.
REQ-029 Without RST_REQ_CAUSE_EN, rst_cause_o SHALL be tied to 3'b000, cause_clr_i SHALL be ignored, no cause flops SHALL exist, and the FSM behaviour SHALL be unchanged.

Structure
REQ-030 The shared package rst_pkg SHALL hold the state enum typedef rst_req_state_e, the cause-bit index constants (CauseSw=0, CauseWdog=1, CauseProg=2), and the cause vector width 3.
REQ-031 The block SHALL contain no sub-modules; the FSM and counter SHALL be inline.

Verification
REQ-032 sw_rst_req_i pulse at cycle 10 with defaults -> prog_rst_no low for cycles 11..26, high from cycle 27; busy_o high for cycles 11..30; rst_cause_o=3'b001.
REQ-033 prog_req_i high for cycles 5..100 -> prog_rst_no low for cycles 6..101; GUARD for cycles 102..105; IDLE at cycle 106; rst_cause_o=3'b100.
REQ-034 sw_rst_req_i and wdog_bite_i both high in cycle 3 -> one 16-cycle pulse; rst_cause_o=3'b011.
REQ-035 A second sw_rst_req_i during ASSERT and another during GUARD -> no extension of the pulse, no new sequence, cause unchanged.
REQ-036 rst_ni low at cycle 8 of ASSERT -> next edge gives prog_rst_no=1, busy_o=0, rst_cause_o=0.
REQ-037 cause_clr_i in the same cycle as a wdog_bite_i trigger, with prior cause 3'b001 -> rst_cause_o=3'b010.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared types and constants for the programmable reset-request controller.
// Holds the FSM state encoding, the cause-bit layout and a helper that packs
// the individual request lines into a cause vector.
package rst_pkg;

    // Width of the sticky cause vector {prog, wdog, sw}
    localparam int CauseW = 3;

    // Bit positions inside the cause vector
    localparam int CauseSw   = 0;
    localparam int CauseWdog = 1;
    localparam int CauseProg = 2;

    // Width of the pulse/guard down-counter
    localparam int CntW = 8;

    // Reset-request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_HOLD   = 2'b10,
        ST_GUARD  = 2'b11
    } rst_req_state_e;

    // Pack the three request lines into their cause-bit positions
    function automatic logic [CauseW-1:0] cause_vec(input logic sw,
                                                    input logic wdog,
                                                    input logic prog);
        logic [CauseW-1:0] v;
        v            = 3'b000;
        v[CauseSw]   = sw;
        v[CauseWdog] = wdog;
        v[CauseProg] = prog;
        return v;
    endfunction

endpackage

// File: rtl/rst_req_ctrl.sv
// Reset-request controller: turns software, watchdog and programming-mode
// requests into a minimum-width active-low reset request for the reset
// manager, followed by a guard window in which new requests are dropped.
// The block must be reset by power-on reset only so it outlives the reset it
// requests.
// Optional feature macro: RST_REQ_CAUSE_EN enables the sticky cause register
// and cause_clr_i; without it rst_cause_o is constant zero.
module rst_req_ctrl
    import rst_pkg::*;
#(
    parameter int PulseCycles = 16,
    parameter int GuardCycles = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sw_rst_req_i,
    input  logic              wdog_bite_i,
    input  logic              prog_req_i,
    input  logic              cause_clr_i,
    output logic              prog_rst_no,
    output logic              busy_o,
    output logic [CauseW-1:0] rst_cause_o
);

    // Counter reload values; the counter runs N-1 down to 0 for N cycles
    localparam logic [CntW-1:0] PulseLoad = CntW'(PulseCycles - 1);
    localparam logic [CntW-1:0] GuardLoad = CntW'(GuardCycles - 1);

    rst_req_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            prog_rst_n_q, prog_rst_n_d;
    logic            busy_q, busy_d;
    logic            req_any_s;

    assign req_any_s = sw_rst_req_i | wdog_bite_i | prog_req_i;

    // Next-state and counter logic for the request sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_d = ST_ASSERT;
                    cnt_d   = PulseLoad;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    // Programming session still active: keep reset held
                    if (prog_req_i) begin
                        state_d = ST_HOLD;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = GuardLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (prog_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_GUARD;
                    cnt_d   = GuardLoad;
                end
            end
            ST_GUARD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with the FSM
    always_comb begin
        prog_rst_n_d = 1'b1;
        busy_d       = 1'b0;
        if ((state_d == ST_ASSERT) || (state_d == ST_HOLD)) begin
            prog_rst_n_d = 1'b0;
        end else begin
            prog_rst_n_d = 1'b1;
        end
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Sequencer state, counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            prog_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prog_rst_n_q <= prog_rst_n_d;
            busy_q       <= busy_d;
        end
    end

    assign prog_rst_no = prog_rst_n_q;
    assign busy_o      = busy_q;

`ifdef RST_REQ_CAUSE_EN
    logic [CauseW-1:0] cause_q, cause_d;
    logic [CauseW-1:0] cause_new_s;

    assign cause_new_s = cause_vec(sw_rst_req_i, wdog_bite_i, prog_req_i);

    // Causes latch only when a request is accepted; a clear in the same
    // cycle wipes older bits but keeps the freshly captured ones
    always_comb begin
        cause_d = cause_q;
        if ((state_q == ST_IDLE) && req_any_s) begin
            if (cause_clr_i) begin
                cause_d = cause_new_s;
            end else begin
                cause_d = cause_q | cause_new_s;
            end
        end else if (cause_clr_i) begin
            cause_d = 3'b000;
        end else begin
            cause_d = cause_q;
        end
    end

    // Sticky cause register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cause_q <= 3'b000;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign rst_cause_o = cause_q;
`else
    logic unused_cause_clr_s;

    assign unused_cause_clr_s = cause_clr_i;
    assign rst_cause_o        = 3'b000;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Self-checking bench for rst_req_ctrl with default parameters.
// Table-driven vector run plus cycle-numbered sequences for the long pulses.
`timescale 1ns/1ps
module tb_rst_req_ctrl;

`ifdef RST_REQ_CAUSE_EN
    localparam logic [2:0] CauseMask = 3'b111;
`else
    localparam logic [2:0] CauseMask = 3'b000;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       sw_rst_req_i;
    logic       wdog_bite_i;
    logic       prog_req_i;
    logic       cause_clr_i;
    logic       prog_rst_no;
    logic       busy_o;
    logic [2:0] rst_cause_o;

    int n_checks = 0;
    int n_errors = 0;

    rst_req_ctrl #(
        .PulseCycles(16),
        .GuardCycles(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sw_rst_req_i(sw_rst_req_i),
        .wdog_bite_i (wdog_bite_i),
        .prog_req_i  (prog_req_i),
        .cause_clr_i (cause_clr_i),
        .prog_rst_no (prog_rst_no),
        .busy_o      (busy_o),
        .rst_cause_o (rst_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         rep;
        logic       rst_n;
        logic       sw;
        logic       wdog;
        logic       prog;
        logic       clr;
        logic       e_prn;
        logic       e_busy;
        logic [2:0] e_cause;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rep, input logic rst_n, input logic sw,
                       input logic wdog, input logic prog, input logic clr,
                       input logic e_prn, input logic e_busy, input logic [2:0] e_cause);
        vec_t v;
        v.rep = rep; v.rst_n = rst_n; v.sw = sw; v.wdog = wdog; v.prog = prog;
        v.clr = clr; v.e_prn = e_prn; v.e_busy = e_busy; v.e_cause = e_cause;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst_n, input logic sw, input logic wdog,
                         input logic prog, input logic clr);
        rst_ni       = rst_n;
        sw_rst_req_i = sw;
        wdog_bite_i  = wdog;
        prog_req_i   = prog;
        cause_clr_i  = clr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(input string name, input int idx,
                              input logic e_prn, input logic e_busy, input logic [2:0] e_cause);
        logic [2:0] ec;
        ec = e_cause & CauseMask;
        n_checks++;
        if ((prog_rst_no !== e_prn) || (busy_o !== e_busy) || (rst_cause_o !== ec)) begin
            n_errors++;
            $display("FAIL %s[%0d]: got prog_rst_no=%b busy=%b cause=%b, want %b %b %b",
                     name, idx, prog_rst_no, busy_o, rst_cause_o, e_prn, e_busy, ec);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        int step;
        logic e_prn, e_busy;
        logic [2:0] e_cause;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // rep, rst_n, sw, wdog, prog, clr, exp prog_rst_no, exp busy, exp cause
        add(2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000); // reset state
        add(3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000); // idle
        add(1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011); // sw+wdog trigger
        add(5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        add(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011); // sw in ASSERT dropped
        add(9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011); // GUARD entry
        add(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011); // sw in GUARD dropped
        add(2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
        add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011); // back to IDLE
        add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000); // clear
        add(1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001); // sw trigger
        add(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        add(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001);
        add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
        add(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b010); // clr+wdog: new wins
        add(7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010); // 8th ASSERT cycle
        add(1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000); // reset aborts
        add(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010); // wdog level held
        add(15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        add(4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010);
        add(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010); // IDLE with wdog high
        add(1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010); // restarts
        add(1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);

        step = 0;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                drive(vecs[i].rst_n, vecs[i].sw, vecs[i].wdog, vecs[i].prog, vecs[i].clr);
                tick();
                check_outs("vec", step, vecs[i].e_prn, vecs[i].e_busy, vecs[i].e_cause);
                step++;
            end
        end

        // Software pulse in cycle 10: low 11..26, busy 11..30
        do_reset();
        for (int c = 0; c < 36; c++) begin
            drive(1'b1, (c == 10), 1'b0, 1'b0, 1'b0);
            tick();
            e_prn   = !((c + 1 >= 11) && (c + 1 <= 26));
            e_busy  = (c + 1 >= 11) && (c + 1 <= 30);
            e_cause = (c + 1 >= 11) ? 3'b001 : 3'b000;
            check_outs("sw_pulse", c + 1, e_prn, e_busy, e_cause);
        end

        // Programming session 5..100: low 6..101, guard 102..105, idle 106
        do_reset();
        for (int c = 0; c < 110; c++) begin
            drive(1'b1, 1'b0, 1'b0, (c >= 5) && (c <= 100), 1'b0);
            tick();
            e_prn   = !((c + 1 >= 6) && (c + 1 <= 101));
            e_busy  = (c + 1 >= 6) && (c + 1 <= 105);
            e_cause = (c + 1 >= 6) ? 3'b100 : 3'b000;
            check_outs("prog_hold", c + 1, e_prn, e_busy, e_cause);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
